// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_loader
// Description : Decodes SPI command bytes, assembles 24-bit pixels into the
//               back bank and applies bank swaps on display frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_loader #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_ss,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  frame_start,
  output logic                  mem_we,
  output logic                  mem_bank,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [23:0]           mem_wdata,
  output logic                  front_bank,
  output logic                  swap_pending,
  output logic                  busy,
  output logic                  err_overflow
);

  localparam logic [7:0] c_CMD_WRITE    = 8'hF0;
  localparam logic [7:0] c_CMD_WRITE_AT = 8'hF1;
  localparam logic [7:0] c_CMD_SWAP     = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_PIXEL   = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_cnt;
  logic [7:0]            r_byte0;
  logic [7:0]            r_byte1;
  // One extra MSB marks "past the last address"; the pointer saturates there.
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [23:0]           r_wdata;
  logic                  r_front;
  logic                  r_pending;
  logic                  r_err;

  logic w_ptr_zero;
  logic w_ptr_load;
  logic w_clr_err;
  logic w_req_swap;
  logic w_byte;
  logic w_pix_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_zero  = 1'b0;
    w_ptr_load  = 1'b0;
    w_clr_err   = 1'b0;
    w_req_swap  = 1'b0;
    w_byte      = 1'b0;
    w_pix_done  = 1'b0;
    if (spi_ss) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_CMD;
        S_CMD: begin
          if (rx_valid) begin
            case (rx_data)
              c_CMD_WRITE: begin
                w_ptr_zero  = 1'b1;
                w_clr_err   = 1'b1;
                w_state_nxt = S_PIXEL;
              end
              c_CMD_WRITE_AT: begin
                w_clr_err   = 1'b1;
                w_state_nxt = S_ADDR;
              end
              c_CMD_SWAP: begin
                w_req_swap  = 1'b1;
                w_state_nxt = S_DISCARD;
              end
              default: w_state_nxt = S_DISCARD;
            endcase
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            w_ptr_load  = 1'b1;
            w_state_nxt = S_PIXEL;
          end
        end
        S_PIXEL: begin
          w_byte     = rx_valid;
          w_pix_done = rx_valid && (r_cnt == 2'd2);
        end
        S_DISCARD: w_state_nxt = S_DISCARD;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 2'd0;
      r_byte0   <= 8'd0;
      r_byte1   <= 8'd0;
      r_ptr     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 24'd0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_ptr_zero) r_ptr <= '0;
      if (w_ptr_load) r_ptr <= {1'b0, rx_data[ADDR_WIDTH-1:0]};
      if (w_clr_err)  r_err <= 1'b0;
      // Partial pixels are dropped whenever the FSM leaves PIXEL.
      if (r_state != S_PIXEL || spi_ss) begin
        r_cnt <= 2'd0;
      end else if (w_byte) begin
        if (r_cnt == 2'd0) r_byte0 <= rx_data;
        if (r_cnt == 2'd1) r_byte1 <= rx_data;
        r_cnt <= w_pix_done ? 2'd0 : r_cnt + 2'd1;
      end
      if (w_pix_done) begin
        if (!r_ptr[ADDR_WIDTH]) begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr[ADDR_WIDTH-1:0];
          r_wdata <= {r_byte0, r_byte1, rx_data};
          r_ptr   <= r_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  // Uses the registered pending flag, so a SWAP decoded alongside a
  // frame_start waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else if (frame_start && r_pending) begin
      r_front   <= ~r_front;
      r_pending <= 1'b0;
    end else if (w_req_swap) begin
      r_pending <= 1'b1;
    end
  end

  assign mem_we       = r_we;
  assign mem_bank     = ~r_front;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign front_bank   = r_front;
  assign swap_pending = r_pending;
  assign busy         = (r_state != S_IDLE);
  assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_loader
// Description : Scoreboard bench for spi_frame_loader pixel writes and swaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_loader;

  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  spi_ss;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  frame_start;
  logic                  mem_we;
  logic                  mem_bank;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [23:0]           mem_wdata;
  logic                  front_bank;
  logic                  swap_pending;
  logic                  busy;
  logic                  err_overflow;

  typedef struct packed {
    logic                  bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [23:0]           data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  logic m_front = 1'b0;
  logic m_err   = 1'b0;

  spi_frame_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_ss       (spi_ss),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .frame_start  (frame_start),
    .mem_we       (mem_we),
    .mem_bank     (mem_bank),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .front_bank   (front_bank),
    .swap_pending (swap_pending),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {27'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("we_addr", {27'd0, mem_addr}, {27'd0, e.addr});
        check("we_data", {8'd0, mem_wdata}, {8'd0, e.data});
        check("we_bank", {31'd0, mem_bank}, {31'd0, e.bank});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic ss_begin;
    spi_ss = 1'b0;
    tick();
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic ss_end;
    spi_ss = 1'b1;
    tick();
    check("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_cmd_write;
    send_byte(8'hF0);
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    send_byte(b0);
    send_byte(b1);
    if (m_ptr < DEPTH) begin
      e.bank = ~m_front;
      e.addr = m_ptr[ADDR_WIDTH-1:0];
      e.data = {b0, b1, b2};
      sb.push_back(e);
      m_ptr++;
    end else begin
      m_err = 1'b1;
    end
    send_byte(b2);
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_front"},   {31'd0, front_bank},   {31'd0, m_front});
    check({tag, "_bank"},    {31'd0, mem_bank},     {31'd0, ~m_front});
    check({tag, "_pending"}, {31'd0, swap_pending}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; spi_ss = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; frame_start = 1'b0;
    tick(); tick();
    check("rst_we",    {31'd0, mem_we},       32'd0);
    check("rst_addr",  {27'd0, mem_addr},     32'd0);
    check("rst_wdata", {8'd0, mem_wdata},     32'd0);
    check("rst_busy",  {31'd0, busy},         32'd0);
    check("rst_err",   {31'd0, err_overflow}, 32'd0);
    check_idle_state("rst");
    rst_n = 1'b1;
    tick();

    // Full bank fill from address 0.
    ss_begin();
    send_cmd_write();
    for (int i = 0; i < DEPTH; i++) send_pixel(8'hFF, 8'(i), 8'hFF);
    check("fill_err", {31'd0, err_overflow}, 32'd0);
    ss_end();

    // Swap request applied at the next frame boundary.
    ss_begin();
    send_byte(8'h10);
    check("swap_pend", {31'd0, swap_pending}, 32'd1);
    ss_end();
    tick();
    check("swap_wait_front", {31'd0, front_bank}, 32'd0);
    pulse_frame();
    m_front = ~m_front;
    check_idle_state("swap1");

    // WRITE_AT near the end: third pixel overflows.
    ss_begin();
    send_byte(8'hF1);
    m_err = 1'b0;
    send_byte(8'h1E);
    m_ptr = 30;
    send_pixel(8'h01, 8'h02, 8'h03);
    send_pixel(8'h04, 8'h05, 8'h06);
    check("ovf_before", {31'd0, err_overflow}, 32'd0);
    send_pixel(8'h07, 8'h08, 8'h09);
    check("ovf_set", {31'd0, err_overflow}, {31'd0, m_err});
    send_pixel(8'h0A, 8'h0B, 8'h0C);
    check("ovf_sticky", {31'd0, err_overflow}, 32'd1);
    ss_end();
    ss_begin();
    send_cmd_write();
    check("ovf_clear", {31'd0, err_overflow}, 32'd0);
    ss_end();

    // Partial pixel aborted by spi_ss, then a fresh write at address 0.
    ss_begin();
    send_cmd_write();
    send_byte(8'hAA);
    send_byte(8'hBB);
    ss_end();
    ss_begin();
    send_cmd_write();
    send_pixel(8'h11, 8'h22, 8'h33);
    ss_end();

    // Two SWAP transactions, two frames: exactly one toggle.
    ss_begin(); send_byte(8'h10); ss_end();
    ss_begin(); send_byte(8'h10); ss_end();
    pulse_frame();
    m_front = ~m_front;
    check_idle_state("dswap1");
    pulse_frame();
    check_idle_state("dswap2");

    // Unknown command: subsequent bytes are discarded.
    ss_begin();
    send_byte(8'h55);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hF0 + i));
    check("unk_pending", {31'd0, swap_pending}, 32'd0);
    ss_end();

    // SWAP byte coincident with frame_start defers to the next frame.
    ss_begin();
    rx_valid = 1'b1; rx_data = 8'h10; frame_start = 1'b1;
    tick();
    rx_valid = 1'b0; frame_start = 1'b0;
    check("coinc_pending", {31'd0, swap_pending}, 32'd1);
    check("coinc_front",   {31'd0, front_bank},   {31'd0, m_front});
    tick();
    ss_end();
    pulse_frame();
    m_front = ~m_front;
    check_idle_state("coinc_apply");

    // Third pixel byte coincident with spi_ss rising is ignored.
    ss_begin();
    send_cmd_write();
    send_byte(8'hCC);
    send_byte(8'hDD);
    rx_valid = 1'b1; rx_data = 8'hEE; spi_ss = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("ssrise_busy", {31'd0, busy}, 32'd0);
    tick();

    // Asynchronous reset mid-pixel discards the pending swap.
    ss_begin(); send_byte(8'h10); ss_end();
    ss_begin();
    send_cmd_write();
    send_pixel(8'h5A, 8'h5B, 8'h5C);
    send_byte(8'h12);
    check("mid_pending", {31'd0, swap_pending}, 32'd1);
    rst_n = 1'b0;
    spi_ss = 1'b1;
    #1;
    m_front = 1'b0;
    m_ptr   = 0;
    check("mrst_we",    {31'd0, mem_we},       32'd0);
    check("mrst_addr",  {27'd0, mem_addr},     32'd0);
    check("mrst_wdata", {8'd0, mem_wdata},     32'd0);
    check("mrst_busy",  {31'd0, busy},         32'd0);
    check("mrst_err",   {31'd0, err_overflow}, 32'd0);
    check_idle_state("mrst");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_frame();
    check_idle_state("mrst_frame");

    tick(); tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
